dmem_arbiter: RTL and testbench

- Shares the single data port (port 1) of the dual-port instruction/data SRAM between two requesters: requester 0 (CPU load/store) and requester 1 (program loader / debug DMA).
- Sits between `riscv` and the SRAM's port 1.
- Provides per-cycle arbitration, write steering and read-data return routing.
- Bounds consecutive grants to one requester so the other cannot be starved.

---
 rtl/dmem_arbiter_if.sv | 47 ++++
 rtl/dmem_arbiter.sv | 148 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// Bundle of the two requester ports and the SRAM port-1 signals that
// dmem_arbiter sits between. The arbiter uses the slave view; whoever
// drives requests and models the SRAM uses the master view.
interface dmem_arbiter_if #(
   parameter int AW = 30,
   parameter int DW = 32
);
   // requester 0
   logic          req0;
   logic          we0;
   logic [AW-1:0] addr0;
   logic [DW-1:0] wdata0;
   logic          gnt0;
   logic          rvalid0;
   logic [DW-1:0] rdata0;
   // requester 1
   logic          req1;
   logic          we1;
   logic [AW-1:0] addr1;
   logic [DW-1:0] wdata1;
   logic          gnt1;
   logic          rvalid1;
   logic [DW-1:0] rdata1;
   // SRAM port 1
   logic [AW-1:0] mem_addr;
   logic          mem_write;
   logic [DW-1:0] mem_write_data;
   logic [DW-1:0] mem_read_data;

   modport slave (
      input  req0, we0, addr0, wdata0,
      input  req1, we1, addr1, wdata1,
      input  mem_read_data,
      output gnt0, rvalid0, rdata0,
      output gnt1, rvalid1, rdata1,
      output mem_addr, mem_write, mem_write_data
   );

   modport master (
      output req0, we0, addr0, wdata0,
      output req1, we1, addr1, wdata1,
      output mem_read_data,
      input  gnt0, rvalid0, rdata0,
      input  gnt1, rvalid1, rdata1,
      input  mem_addr, mem_write, mem_write_data
   );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for the data port of the instruction/data SRAM.
// Requester 0 is the CPU load/store unit, requester 1 the loader/debug DMA.
// Grants are combinational; read data comes back one cycle after the grant
// and is steered to whichever requester issued the read. A hold counter
// caps consecutive grants to one side while the other side is waiting.
module dmem_arbiter #(
   parameter int AW         = 30,
   parameter int DW         = 32,
   parameter int MAX_HOLD   = 4,
   parameter int FIXED_PRIO = 0
) (
   input logic          clk,
   input logic          rst,
   dmem_arbiter_if.slave bus
);

   localparam logic [3:0] HOLD_MAX = 4'(MAX_HOLD);

   logic          last_r;       // winner of the most recent grant
   logic [3:0]    hold_r;       // consecutive grants given to last_r
   logic          rd_pend_r;    // a read was accepted last cycle
   logic          rd_owner_r;   // requester that issued that read
   logic [AW-1:0] mem_addr_r;   // address of the most recent grant

   logic          any_s;        // some requester is granted this cycle
   logic          win_s;        // index of the granted requester
   logic          win_we_s;
   logic [AW-1:0] win_addr_s;
   logic [DW-1:0] win_wdata_s;
   logic          rvalid0_s;
   logic          rvalid1_s;

   // Pick the winner: lone requester wins, contention uses priority/round-robin with the hold cap
   always_comb begin
      any_s = 1'b0;
      win_s = last_r;
      if (rst) begin
         any_s = 1'b0;
         win_s = last_r;
      end else if (bus.req0 && bus.req1) begin
         any_s = 1'b1;
         if (hold_r == HOLD_MAX) begin
            win_s = ~last_r;
         end else if (FIXED_PRIO != 0) begin
            win_s = 1'b0;
         end else begin
            win_s = ~last_r;
         end
      end else if (bus.req0) begin
         any_s = 1'b1;
         win_s = 1'b0;
      end else if (bus.req1) begin
         any_s = 1'b1;
         win_s = 1'b1;
      end else begin
         any_s = 1'b0;
         win_s = last_r;
      end
   end

   // Select the winner's command fields
   always_comb begin
      win_we_s    = 1'b0;
      win_addr_s  = {AW{1'b0}};
      win_wdata_s = {DW{1'b0}};
      case (win_s)
         1'b0: begin
            win_we_s    = bus.we0;
            win_addr_s  = bus.addr0;
            win_wdata_s = bus.wdata0;
         end
         1'b1: begin
            win_we_s    = bus.we1;
            win_addr_s  = bus.addr1;
            win_wdata_s = bus.wdata1;
         end
         default: begin
            win_we_s    = 1'b0;
            win_addr_s  = {AW{1'b0}};
            win_wdata_s = {DW{1'b0}};
         end
      endcase
   end

   // Drive grants and the SRAM port; an idle port keeps the last address and never writes
   always_comb begin
      bus.gnt0           = any_s & ~win_s;
      bus.gnt1           = any_s & win_s;
      bus.mem_addr       = mem_addr_r;
      bus.mem_write      = 1'b0;
      bus.mem_write_data = {DW{1'b0}};
      if (any_s) begin
         bus.mem_addr       = win_addr_s;
         bus.mem_write      = win_we_s;
         bus.mem_write_data = win_wdata_s;
      end else begin
         bus.mem_addr       = mem_addr_r;
         bus.mem_write      = 1'b0;
         bus.mem_write_data = {DW{1'b0}};
      end
   end

   // Route the SRAM read data to the owner of last cycle's read; the other side sees zero
   always_comb begin
      rvalid0_s   = rd_pend_r & ~rd_owner_r;
      rvalid1_s   = rd_pend_r & rd_owner_r;
      bus.rvalid0 = rvalid0_s;
      bus.rvalid1 = rvalid1_s;
      bus.rdata0  = {DW{1'b0}};
      bus.rdata1  = {DW{1'b0}};
      if (rvalid0_s) begin
         bus.rdata0 = bus.mem_read_data;
      end else begin
         bus.rdata0 = {DW{1'b0}};
      end
      if (rvalid1_s) begin
         bus.rdata1 = bus.mem_read_data;
      end else begin
         bus.rdata1 = {DW{1'b0}};
      end
   end

   // Arbitration history, pending-read tracking and the held SRAM address
   always_ff @(posedge clk) begin
      if (rst) begin
         last_r     <= 1'b1;
         hold_r     <= 4'd0;
         rd_pend_r  <= 1'b0;
         rd_owner_r <= 1'b0;
         mem_addr_r <= {AW{1'b0}};
      end else begin
         rd_pend_r  <= any_s & ~win_we_s;
         rd_owner_r <= win_s;
         if (any_s) begin
            mem_addr_r <= win_addr_s;
            last_r     <= win_s;
            if (win_s == last_r) begin
               hold_r <= (hold_r >= HOLD_MAX) ? HOLD_MAX : hold_r + 4'd1;
            end else begin
               hold_r <= 4'd1;
            end
         end else begin
            hold_r <= 4'd0;
         end
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: one round-robin instance backed by a small
// SRAM model, one fixed-priority instance for the hold-cap grant pattern.
module tb_dmem_arbiter;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   dmem_arbiter_if #(.AW(30), .DW(32)) bus_a ();
   dmem_arbiter_if #(.AW(30), .DW(32)) bus_b ();

   dmem_arbiter #(.AW(30), .DW(32), .MAX_HOLD(4), .FIXED_PRIO(0)) dut_a (
      .clk (clk),
      .rst (rst),
      .bus (bus_a)
   );

   dmem_arbiter #(.AW(30), .DW(32), .MAX_HOLD(4), .FIXED_PRIO(1)) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (bus_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // SRAM model for instance A: registered read, write on mem_write, word 0x10 preloaded
   logic [31:0] mem_a [0:255];
   always @(posedge clk) begin
      if (rst) mem_a[8'h10] <= 32'hDEADBEEF;
      if (bus_a.mem_write) mem_a[bus_a.mem_addr[7:0]] <= bus_a.mem_write_data;
      bus_a.mem_read_data <= mem_a[bus_a.mem_addr[7:0]];
   end

   // SRAM stand-in for instance B: read data echoes the address
   always @(posedge clk) begin
      bus_b.mem_read_data <= {2'b00, bus_b.mem_addr};
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      logic w;
      logic prev;
      checks = 0;
      errors = 0;
      rst = 1'b1;
      bus_a.req0 = 1'b0; bus_a.we0 = 1'b0; bus_a.addr0 = 30'h0; bus_a.wdata0 = 32'h0;
      bus_a.req1 = 1'b0; bus_a.we1 = 1'b0; bus_a.addr1 = 30'h0; bus_a.wdata1 = 32'h0;
      bus_b.req0 = 1'b0; bus_b.we0 = 1'b0; bus_b.addr0 = 30'h0; bus_b.wdata0 = 32'h0;
      bus_b.req1 = 1'b0; bus_b.we1 = 1'b0; bus_b.addr1 = 30'h0; bus_b.wdata1 = 32'h0;

      // reset state, request present while in reset
      @(negedge clk);
      bus_a.req0 = 1'b1; bus_a.addr0 = 30'h10;
      #1;
      chk("rst_gnt0", bus_a.gnt0, 1'b0);
      chk("rst_gnt1", bus_a.gnt1, 1'b0);
      chk("rst_mem_write", bus_a.mem_write, 1'b0);
      chk("rst_mem_addr", bus_a.mem_addr, 30'h0);
      chk("rst_rvalid0", bus_a.rvalid0, 1'b0);
      chk("rst_rvalid1", bus_a.rvalid1, 1'b0);
      chk("rst_rdata0", bus_a.rdata0, 32'h0);
      chk("rst_b_gnt0", bus_b.gnt0, 1'b0);

      // req0 read of 0x10
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rd0_gnt0", bus_a.gnt0, 1'b1);
      chk("rd0_gnt1", bus_a.gnt1, 1'b0);
      chk("rd0_mem_addr", bus_a.mem_addr, 30'h10);
      chk("rd0_mem_write", bus_a.mem_write, 1'b0);
      @(negedge clk);
      bus_a.req0 = 1'b0;
      #1;
      chk("rd0_rvalid0", bus_a.rvalid0, 1'b1);
      chk("rd0_rdata0", bus_a.rdata0, 32'hDEADBEEF);
      chk("rd0_rvalid1", bus_a.rvalid1, 1'b0);
      chk("rd0_rdata1", bus_a.rdata1, 32'h0);
      chk("idle_gnt0", bus_a.gnt0, 1'b0);
      chk("idle_addr_hold", bus_a.mem_addr, 30'h10);
      chk("idle_wdata", bus_a.mem_write_data, 32'h0);

      // req1 write 0x20 then read it back
      @(negedge clk);
      bus_a.req1 = 1'b1; bus_a.we1 = 1'b1; bus_a.addr1 = 30'h20; bus_a.wdata1 = 32'h12345678;
      #1;
      chk("wr1_gnt1", bus_a.gnt1, 1'b1);
      chk("wr1_gnt0", bus_a.gnt0, 1'b0);
      chk("wr1_mem_write", bus_a.mem_write, 1'b1);
      chk("wr1_mem_addr", bus_a.mem_addr, 30'h20);
      chk("wr1_mem_wdata", bus_a.mem_write_data, 32'h12345678);
      @(negedge clk);
      bus_a.we1 = 1'b0;
      #1;
      chk("rd1_mem_write", bus_a.mem_write, 1'b0);
      chk("rd1_gnt1", bus_a.gnt1, 1'b1);
      chk("wr1_no_rvalid", bus_a.rvalid1, 1'b0);
      @(negedge clk);
      bus_a.req1 = 1'b0;
      #1;
      chk("rd1_rvalid1", bus_a.rvalid1, 1'b1);
      chk("rd1_rdata1", bus_a.rdata1, 32'h12345678);
      chk("rd1_rvalid0", bus_a.rvalid0, 1'b0);
      chk("rd1_rdata0", bus_a.rdata0, 32'h0);

      // both reading continuously: round-robin alternates starting with 0
      @(negedge clk);
      bus_a.req0 = 1'b1; bus_a.we0 = 1'b0; bus_a.addr0 = 30'h10;
      bus_a.req1 = 1'b1; bus_a.we1 = 1'b0; bus_a.addr1 = 30'h20;
      for (int i = 0; i < 5; i++) begin
         if (i > 0) @(negedge clk);
         #1;
         w = 1'(i % 2);
         chk("rr_gnt1", bus_a.gnt1, w);
         chk("rr_gnt0", bus_a.gnt0, (w == 1'b0));
         chk("rr_mem_addr", bus_a.mem_addr, w ? 30'h20 : 30'h10);
         if (i > 0) begin
            prev = 1'((i - 1) % 2);
            chk("rr_rvalid0", bus_a.rvalid0, (prev == 1'b0));
            chk("rr_rvalid1", bus_a.rvalid1, prev);
            chk("rr_rdata0", bus_a.rdata0, prev ? 32'h0 : 32'hDEADBEEF);
            chk("rr_rdata1", bus_a.rdata1, prev ? 32'h12345678 : 32'h0);
         end
      end

      // req0 waits behind req1, then drops without ever being granted
      @(negedge clk);
      #1;
      chk("drop_wait_gnt0", bus_a.gnt0, 1'b0);
      chk("drop_wait_gnt1", bus_a.gnt1, 1'b1);
      chk("drop_wait_addr", bus_a.mem_addr, 30'h20);
      chk("drop_prev_rvalid0", bus_a.rvalid0, 1'b1);
      chk("drop_prev_rdata0", bus_a.rdata0, 32'hDEADBEEF);
      @(negedge clk);
      bus_a.req0 = 1'b0;
      #1;
      chk("drop_gnt0", bus_a.gnt0, 1'b0);
      chk("drop_gnt1", bus_a.gnt1, 1'b1);
      chk("drop_addr", bus_a.mem_addr, 30'h20);
      chk("drop_rvalid0_a", bus_a.rvalid0, 1'b0);
      chk("drop_rvalid1_a", bus_a.rvalid1, 1'b1);
      @(negedge clk);
      bus_a.req1 = 1'b0;
      #1;
      chk("drop_rvalid0_b", bus_a.rvalid0, 1'b0);
      chk("drop_rvalid1_b", bus_a.rvalid1, 1'b1);
      chk("drop_rdata1_b", bus_a.rdata1, 32'h12345678);
      chk("drop_idle_gnt1", bus_a.gnt1, 1'b0);

      // reset in the cycle a req0 read would be granted
      @(negedge clk);
      rst = 1'b1;
      bus_a.req0 = 1'b1; bus_a.we0 = 1'b0; bus_a.addr0 = 30'h10;
      #1;
      chk("midrst_gnt0", bus_a.gnt0, 1'b0);
      chk("midrst_mem_write", bus_a.mem_write, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      bus_a.req0 = 1'b0;
      bus_a.req1 = 1'b1; bus_a.we1 = 1'b0; bus_a.addr1 = 30'h20;
      #1;
      chk("midrst_rvalid0", bus_a.rvalid0, 1'b0);
      chk("postrst_gnt1", bus_a.gnt1, 1'b1);
      chk("postrst_gnt0", bus_a.gnt0, 1'b0);
      @(negedge clk);
      bus_a.req1 = 1'b0;
      #1;
      chk("postrst_rvalid1", bus_a.rvalid1, 1'b1);
      chk("postrst_rdata1", bus_a.rdata1, 32'h12345678);

      // fixed priority with hold cap 4: 0,0,0,0,1 repeating
      @(negedge clk);
      bus_b.req0 = 1'b1; bus_b.we0 = 1'b0; bus_b.addr0 = 30'h100;
      bus_b.req1 = 1'b1; bus_b.we1 = 1'b0; bus_b.addr1 = 30'h200;
      for (int i = 0; i < 10; i++) begin
         if (i > 0) @(negedge clk);
         #1;
         w = ((i % 5) == 4);
         chk("fix_gnt1", bus_b.gnt1, w);
         chk("fix_gnt0", bus_b.gnt0, (w == 1'b0));
         chk("fix_addr", bus_b.mem_addr, w ? 30'h200 : 30'h100);
      end
      @(negedge clk);
      bus_b.req0 = 1'b0;
      bus_b.req1 = 1'b0;
      #1;
      chk("fix_rvalid1", bus_b.rvalid1, 1'b1);
      chk("fix_rdata1", bus_b.rdata1, 32'h200);
      chk("fix_rvalid0", bus_b.rvalid0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
